// File: rtl/decode_pkg.sv
// Shared types and encoding constants for the decode queue and its decoder.
package decode_pkg;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 47;

    // One-hot instruction format; EN_NONE marks an illegal record.
    typedef enum logic [5:0] {
        EN_NONE = 6'b000000,
        EN_R    = 6'b000001,
        EN_I    = 6'b000010,
        EN_S    = 6'b000100,
        EN_B    = 6'b001000,
        EN_U    = 6'b010000,
        EN_J    = 6'b100000
    } EncodingType;

    // Bit positions inside the one-hot operation vector.
    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_idx_e;

    typedef logic [OP_W-1:0] InstructionSetM;

    // Decoded record; the PC is stored alongside because its width is a top parameter.
    typedef struct packed {
        EncodingType    en;
        InstructionSetM op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [ILEN-1:0]  imm;
        logic             illegal;
    } decoded_t;

    // Major opcodes, inst[6:2].
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic InstructionSetM op_onehot(input op_idx_e o);
        return InstructionSetM'(1) << o;
    endfunction

endpackage

// File: rtl/decode_queue_core.sv
// Purely combinational RV32I(+M) instruction decoder.
module decode_core
    import decode_pkg::*;
#(
    parameter int unsigned M_EXT = 1
) (
    input  logic [31:0] inst,
    output decoded_t    dec_c
);

    logic [4:0]     opc;
    logic [2:0]     f3;
    logic [6:0]     f7;
    InstructionSetM op_c;
    EncodingType    fmt_c;
    logic           illegal_c;

    assign opc = inst[6:2];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    // Select operation and format; an empty op vector means illegal.
    always_comb begin
        op_c  = '0;
        fmt_c = EN_NONE;
        if (inst[1:0] == 2'b11) begin
            case (opc)
                OPC_LUI:   begin fmt_c = EN_U; op_c = op_onehot(OP_LUI);   end
                OPC_AUIPC: begin fmt_c = EN_U; op_c = op_onehot(OP_AUIPC); end
                OPC_JAL:   begin fmt_c = EN_J; op_c = op_onehot(OP_JAL);   end
                OPC_JALR: begin
                    fmt_c = EN_I;
                    if (f3 == 3'b000) op_c = op_onehot(OP_JALR);
                end
                OPC_BRANCH: begin
                    fmt_c = EN_B;
                    case (f3)
                        3'b000:  op_c = op_onehot(OP_BEQ);
                        3'b001:  op_c = op_onehot(OP_BNE);
                        3'b100:  op_c = op_onehot(OP_BLT);
                        3'b101:  op_c = op_onehot(OP_BGE);
                        3'b110:  op_c = op_onehot(OP_BLTU);
                        3'b111:  op_c = op_onehot(OP_BGEU);
                        default: op_c = '0;
                    endcase
                end
                OPC_LOAD: begin
                    fmt_c = EN_I;
                    case (f3)
                        3'b000:  op_c = op_onehot(OP_LB);
                        3'b001:  op_c = op_onehot(OP_LH);
                        3'b010:  op_c = op_onehot(OP_LW);
                        3'b100:  op_c = op_onehot(OP_LBU);
                        3'b101:  op_c = op_onehot(OP_LHU);
                        default: op_c = '0;
                    endcase
                end
                OPC_STORE: begin
                    fmt_c = EN_S;
                    case (f3)
                        3'b000:  op_c = op_onehot(OP_SB);
                        3'b001:  op_c = op_onehot(OP_SH);
                        3'b010:  op_c = op_onehot(OP_SW);
                        default: op_c = '0;
                    endcase
                end
                OPC_OP_IMM: begin
                    fmt_c = EN_I;
                    case (f3)
                        3'b000: op_c = op_onehot(OP_ADDI);
                        3'b010: op_c = op_onehot(OP_SLTI);
                        3'b011: op_c = op_onehot(OP_SLTIU);
                        3'b100: op_c = op_onehot(OP_XORI);
                        3'b110: op_c = op_onehot(OP_ORI);
                        3'b111: op_c = op_onehot(OP_ANDI);
                        3'b001: if (f7 == F7_BASE) op_c = op_onehot(OP_SLLI);
                        default: begin
                            if (f7 == F7_BASE)     op_c = op_onehot(OP_SRLI);
                            else if (f7 == F7_ALT) op_c = op_onehot(OP_SRAI);
                        end
                    endcase
                end
                OPC_OP: begin
                    fmt_c = EN_R;
                    if (f7 == F7_BASE) begin
                        case (f3)
                            3'b000:  op_c = op_onehot(OP_ADD);
                            3'b001:  op_c = op_onehot(OP_SLL);
                            3'b010:  op_c = op_onehot(OP_SLT);
                            3'b011:  op_c = op_onehot(OP_SLTU);
                            3'b100:  op_c = op_onehot(OP_XOR);
                            3'b101:  op_c = op_onehot(OP_SRL);
                            3'b110:  op_c = op_onehot(OP_OR);
                            default: op_c = op_onehot(OP_AND);
                        endcase
                    end else if (f7 == F7_ALT) begin
                        case (f3)
                            3'b000:  op_c = op_onehot(OP_SUB);
                            3'b101:  op_c = op_onehot(OP_SRA);
                            default: op_c = '0;
                        endcase
                    end else if (f7 == F7_MULDIV && M_EXT != 0) begin
                        case (f3)
                            3'b000:  op_c = op_onehot(OP_MUL);
                            3'b001:  op_c = op_onehot(OP_MULH);
                            3'b010:  op_c = op_onehot(OP_MULHSU);
                            3'b011:  op_c = op_onehot(OP_MULHU);
                            3'b100:  op_c = op_onehot(OP_DIV);
                            3'b101:  op_c = op_onehot(OP_DIVU);
                            3'b110:  op_c = op_onehot(OP_REM);
                            default: op_c = op_onehot(OP_REMU);
                        endcase
                    end
                end
                OPC_SYSTEM: begin
                    fmt_c = EN_I;
                    // Only the exact ECALL/EBREAK encodings are supported; no CSR ops.
                    if (inst[31:7] == 25'h0000000)      op_c = op_onehot(OP_ECALL);
                    else if (inst[31:7] == 25'h0002000) op_c = op_onehot(OP_EBREAK);
                end
                default: op_c = '0;
            endcase
        end
        illegal_c = (op_c == '0);
    end

    // Build the record; fields not used by the format and all fields of an illegal record are zero.
    always_comb begin
        dec_c         = '0;
        dec_c.illegal = illegal_c;
        if (!illegal_c) begin
            dec_c.en = fmt_c;
            dec_c.op = op_c;
            case (fmt_c)
                EN_R: begin
                    dec_c.rd  = inst[11:7];
                    dec_c.rs1 = inst[19:15];
                    dec_c.rs2 = inst[24:20];
                end
                EN_I: begin
                    dec_c.rd  = inst[11:7];
                    dec_c.rs1 = inst[19:15];
                    dec_c.imm = {{20{inst[31]}}, inst[31:20]};
                end
                EN_S: begin
                    dec_c.rs1 = inst[19:15];
                    dec_c.rs2 = inst[24:20];
                    dec_c.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                end
                EN_B: begin
                    dec_c.rs1 = inst[19:15];
                    dec_c.rs2 = inst[24:20];
                    dec_c.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                EN_U: begin
                    dec_c.rd  = inst[11:7];
                    dec_c.imm = {inst[31:12], 12'h000};
                end
                EN_J: begin
                    dec_c.rd  = inst[11:7];
                    dec_c.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                default: dec_c.imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decode on entry, FIFO of decoded records, trap stall and flush.
module decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned XLEN             = 32,
    parameter int unsigned M_EXT            = 1,
    parameter int unsigned STALL_ON_ILLEGAL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output EncodingType              out_en,
    output InstructionSetM           out_op,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [31:0]              out_imm,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     trap_pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    decoded_t         wr_rec_c;
    decoded_t         head_rec;
    decoded_t         rec_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             trap_q, trap_d;
    logic             push_c, pop_c;

    decode_core #(.M_EXT(M_EXT)) u_decode (
        .inst  (in_inst),
        .dec_c (wr_rec_c)
    );

    assign in_ready  = (count_q != CNT_W'(DEPTH)) && !trap_q;
    assign out_valid = (count_q != '0);
    assign push_c    = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;

    // Pointer, occupancy and stall update; flush overrides any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        trap_d   = trap_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            trap_d   = 1'b0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push_c && wr_rec_c.illegal && STALL_ON_ILLEGAL != 0) trap_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            trap_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            trap_q   <= trap_d;
        end
    end

    // Record storage; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        if (push_c && !flush) begin
            rec_mem_q[wr_ptr_q] <= wr_rec_c;
            pc_mem_q[wr_ptr_q]  <= in_pc;
        end
    end

    assign head_rec     = rec_mem_q[rd_ptr_q];
    assign out_pc       = pc_mem_q[rd_ptr_q];
    assign out_en       = head_rec.en;
    assign out_op       = head_rec.op;
    assign out_rd       = head_rec.rd;
    assign out_rs1      = head_rec.rs1;
    assign out_rs2      = head_rec.rs2;
    assign out_imm      = head_rec.imm;
    assign out_illegal  = head_rec.illegal;
    assign count        = count_q;
    assign trap_pending = trap_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: queue-level reference model plus hand-decoded vector table.
module tb_decode_queue;
    import decode_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] inst;
        EncodingType en;
        op_idx_e     op;
        logic        ill;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } vec_t;

    typedef struct {
        logic [31:0]    pc;
        EncodingType    en;
        InstructionSetM op;
        logic [4:0]     rd, rs1, rs2;
        logic [31:0]    imm;
        logic           ill;
    } exp_t;

    localparam int V_ADDI = 0, V_MUL = 1, V_ADD = 2, V_SUB = 3, V_LW = 4, V_SW = 5,
                   V_BEQ = 6, V_LUI = 7, V_JAL = 8, V_SRAI = 9, V_DIVU = 10, V_NOP = 11,
                   V_ZERO = 12, V_ECALL = 13, V_BADF7 = 14, V_ECALLBAD = 15;

    vec_t vt [16];

    logic clk, rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic in_ready, out_valid, out_illegal, trap_pending;
    logic [31:0] out_pc, out_imm;
    EncodingType out_en;
    InstructionSetM out_op;
    logic [4:0] out_rd, out_rs1, out_rs2;
    logic [2:0] count;

    logic n_flush, n_in_valid, n_out_ready;
    logic [31:0] n_in_inst, n_in_pc;
    logic n_in_ready, n_out_valid, n_out_illegal, n_trap;
    logic [31:0] n_out_pc, n_out_imm;
    EncodingType n_out_en;
    InstructionSetM n_out_op;
    logic [4:0] n_out_rd, n_out_rs1, n_out_rs2;
    logic [2:0] n_count;

    int n_vec = 0;
    int n_err = 0;

    vec_t cur_vec;
    exp_t mq[$];
    bit   m_trap;

    decode_queue #(.DEPTH(DEPTH), .XLEN(32), .M_EXT(1), .STALL_ON_ILLEGAL(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_en(out_en), .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal), .count(count),
        .trap_pending(trap_pending)
    );

    decode_queue #(.DEPTH(DEPTH), .XLEN(32), .M_EXT(0), .STALL_ON_ILLEGAL(1)) dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_inst(n_in_inst), .in_pc(n_in_pc), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_pc(n_out_pc), .out_en(n_out_en), .out_op(n_out_op), .out_rd(n_out_rd),
        .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_imm(n_out_imm),
        .out_illegal(n_out_illegal), .count(n_count), .trap_pending(n_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input vec_t v, input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ill = v.ill;
        if (v.ill) begin
            e.en = EN_NONE; e.op = '0; e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.imm = '0;
        end else begin
            e.en = v.en; e.op = InstructionSetM'(1) << v.op;
            e.rd = v.rd; e.rs1 = v.rs1; e.rs2 = v.rs2; e.imm = v.imm;
        end
        return e;
    endfunction

    // Reference model: a bounded queue with a sticky trap flag, flush wins over everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_trap = 1'b0;
        end else begin
            bit m_push, m_pop;
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = in_valid && (mq.size() < DEPTH) && !m_trap;
            if (flush) begin
                mq.delete();
                m_trap = 1'b0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back(mk_exp(cur_vec, in_pc));
                    if (cur_vec.ill) m_trap = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'((mq.size() < DEPTH) && !m_trap));
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("count", 64'(count), 64'(mq.size()));
            chk("trap_pending", 64'(trap_pending), 64'(m_trap));
            if (out_valid && mq.size() != 0) begin
                chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
                chk("out_en", 64'(out_en), 64'(mq[0].en));
                chk("out_op", 64'(out_op), 64'(mq[0].op));
                chk("out_rd", 64'(out_rd), 64'(mq[0].rd));
                chk("out_rs1", 64'(out_rs1), 64'(mq[0].rs1));
                chk("out_rs2", 64'(out_rs2), 64'(mq[0].rs2));
                chk("out_imm", 64'(out_imm), 64'(mq[0].imm));
                chk("out_illegal", 64'(out_illegal), 64'(mq[0].ill));
            end
        end
    end

    task automatic send(input int idx, input logic [31:0] pc);
        bit done;
        done     = 1'b0;
        cur_vec  = vt[idx];
        in_inst  = vt[idx].inst;
        in_pc    = pc;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            #1;
            if (mq.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        vt[V_ADDI]     = '{32'h00500093, EN_I, OP_ADDI,  1'b0, 5'd1,  5'd0, 5'd0, 32'd5};
        vt[V_MUL]      = '{32'h022081B3, EN_R, OP_MUL,   1'b0, 5'd3,  5'd1, 5'd2, 32'd0};
        vt[V_ADD]      = '{32'h007302B3, EN_R, OP_ADD,   1'b0, 5'd5,  5'd6, 5'd7, 32'd0};
        vt[V_SUB]      = '{32'h403100B3, EN_R, OP_SUB,   1'b0, 5'd1,  5'd2, 5'd3, 32'd0};
        vt[V_LW]       = '{32'hFFC12403, EN_I, OP_LW,    1'b0, 5'd8,  5'd2, 5'd0, 32'hFFFFFFFC};
        vt[V_SW]       = '{32'h00512423, EN_S, OP_SW,    1'b0, 5'd0,  5'd2, 5'd5, 32'd8};
        vt[V_BEQ]      = '{32'hFE208CE3, EN_B, OP_BEQ,   1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFFFFF8};
        vt[V_LUI]      = '{32'h12345537, EN_U, OP_LUI,   1'b0, 5'd10, 5'd0, 5'd0, 32'h12345000};
        vt[V_JAL]      = '{32'h010000EF, EN_J, OP_JAL,   1'b0, 5'd1,  5'd0, 5'd0, 32'd16};
        vt[V_SRAI]     = '{32'h40315093, EN_I, OP_SRAI,  1'b0, 5'd1,  5'd2, 5'd0, 32'h00000403};
        vt[V_DIVU]     = '{32'h0262D233, EN_R, OP_DIVU,  1'b0, 5'd4,  5'd5, 5'd6, 32'd0};
        vt[V_NOP]      = '{32'h00000013, EN_I, OP_ADDI,  1'b0, 5'd0,  5'd0, 5'd0, 32'd0};
        vt[V_ZERO]     = '{32'h00000000, EN_NONE, OP_LUI, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0};
        vt[V_ECALL]    = '{32'h00000073, EN_I, OP_ECALL, 1'b0, 5'd0,  5'd0, 5'd0, 32'd0};
        vt[V_BADF7]    = '{32'h80000033, EN_NONE, OP_LUI, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0};
        vt[V_ECALLBAD] = '{32'h000000F3, EN_NONE, OP_LUI, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; cur_vec = vt[V_NOP];
        n_flush = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0; n_in_inst = '0; n_in_pc = '0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_count", 64'(count), 64'(0));

        // Single ADDI with consumer ready.
        out_ready = 1'b1;
        send(V_ADDI, 32'h100);
        chk("addi_valid", 64'(out_valid), 64'(1));
        chk("addi_op", 64'(out_op[OP_ADDI]), 64'(1));
        chk("addi_onehot", 64'($countones(out_op)), 64'(1));
        chk("addi_en", 64'(out_en), 64'(6'b000010));
        chk("addi_rd", 64'(out_rd), 64'(1));
        chk("addi_rs1", 64'(out_rs1), 64'(0));
        chk("addi_imm", 64'(out_imm), 64'(5));
        chk("addi_pc", 64'(out_pc), 64'(32'h100));
        @(posedge clk); #1;
        chk("addi_popped", 64'(count), 64'(0));

        // MUL decodes with M_EXT=1 and is illegal with M_EXT=0.
        send(V_MUL, 32'h104);
        chk("mul_op", 64'(out_op[OP_MUL]), 64'(1));
        chk("mul_en", 64'(out_en), 64'(6'b000001));
        n_in_inst = 32'h022081B3; n_in_pc = 32'h104; n_in_valid = 1'b1;
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        chk("nom_illegal", 64'(n_out_illegal), 64'(1));
        chk("nom_op", 64'(n_out_op), 64'(0));
        chk("nom_trap", 64'(n_trap), 64'(1));
        chk("nom_in_ready", 64'(n_in_ready), 64'(0));
        n_flush = 1'b1;
        @(posedge clk); #1;
        n_flush = 1'b0;
        chk("nom_flush_ready", 64'(n_in_ready), 64'(1));
        chk("nom_flush_count", 64'(n_count), 64'(0));
        wait_empty();

        // Fill while stalled, then stream through so the pointers wrap.
        out_ready = 1'b0;
        send(V_ADD, 32'h200);
        send(V_SUB, 32'h204);
        send(V_LW,  32'h208);
        send(V_SW,  32'h20C);
        chk("full_count", 64'(count), 64'(4));
        chk("full_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        send(V_BEQ,  32'h210);
        send(V_LUI,  32'h214);
        send(V_JAL,  32'h218);
        send(V_SRAI, 32'h21C);
        send(V_DIVU, 32'h220);
        send(V_ECALL, 32'h224);
        wait_empty();

        // Illegal instruction stalls fetch until flush.
        out_ready = 1'b0;
        send(V_NOP,  32'h300);
        send(V_ZERO, 32'h304);
        chk("trap_set", 64'(trap_pending), 64'(1));
        chk("trap_in_ready", 64'(in_ready), 64'(0));
        chk("trap_count", 64'(count), 64'(2));
        out_ready = 1'b1;
        cur_vec = vt[V_LUI]; in_inst = vt[V_LUI].inst; in_pc = 32'h308; in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("trap_drained", 64'(count), 64'(0));
        chk("trap_hold", 64'(in_ready), 64'(0));
        pulse_flush();
        chk("flush_ready", 64'(in_ready), 64'(1));
        chk("flush_trap", 64'(trap_pending), 64'(0));

        // Flush with count=3 plus a simultaneous push and pop.
        out_ready = 1'b0;
        send(V_ADD, 32'h400);
        send(V_SUB, 32'h404);
        send(V_LW,  32'h408);
        cur_vec = vt[V_LUI]; in_inst = vt[V_LUI].inst; in_pc = 32'h40C; in_valid = 1'b1;
        out_ready = 1'b1;
        pulse_flush();
        in_valid = 1'b0;
        chk("flush3_count", 64'(count), 64'(0));
        chk("flush3_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk("flush3_nopush", 64'(out_valid), 64'(0));

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(V_ADD, 32'h500);
        send(V_SUB, 32'h504);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_ready", 64'(in_ready), 64'(1));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Other illegal encodings, then legal system and M ops after the stall clears.
        out_ready = 1'b1;
        send(V_BADF7, 32'h600);
        chk("badf7_illegal", 64'(out_illegal), 64'(1));
        wait_empty();
        pulse_flush();
        send(V_ECALLBAD, 32'h604);
        chk("ecallbad_illegal", 64'(out_illegal), 64'(1));
        wait_empty();
        pulse_flush();
        send(V_ECALL, 32'h608);
        chk("ecall_op", 64'(out_op[OP_ECALL]), 64'(1));
        send(V_DIVU, 32'h60C);
        wait_empty();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
